// File: rtl/decode_sb.sv
// decode_sb: LC-3b decode stage with register file, condition-code register,
// per-register scoreboard, writeback bypass and a one-entry output register.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          fetch handshake; in_npc, in_ir carry the instruction
//   out_valid/out_ready        downstream handshake
//   out_npc, out_ir            registered npc / instruction
//   out_sr1, out_sr2           operand values read at issue
//   out_drid                   destination register id
//   out_cc                     NZP at issue
//   out_ld_reg, out_ld_cc      instruction writes a register / the CC
//   flush                      drop the output register and the input this cycle
//   wb_valid, wb_we            retirement of one counted instruction (we=0: squashed)
//   wb_drid, wb_data           register and value to commit
//   wb_ld_reg, wb_ld_cc, wb_cc flags as issued, new NZP
module decode_sb #(
  parameter int WIDTH        = 16,
  parameter int NREGS        = 8,
  parameter int LINK_REG     = 7,
  parameter int MAX_INFLIGHT = 4,
  localparam int REG_W = $clog2(NREGS),
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_npc,
  input  logic [15:0]      in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_npc,
  output logic [15:0]      out_ir,
  output logic [WIDTH-1:0] out_sr1,
  output logic [WIDTH-1:0] out_sr2,
  output logic [REG_W-1:0] out_drid,
  output logic [2:0]       out_cc,
  output logic             out_ld_reg,
  output logic             out_ld_cc,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_drid,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             wb_ld_reg,
  input  logic             wb_ld_cc,
  input  logic [2:0]       wb_cc
);

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LDB = 4'b0010, OP_STB  = 4'b0011,
    OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDW = 4'b0110, OP_STW  = 4'b0111,
    OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI  = 4'b1011,
    OP_JMP = 4'b1100, OP_SHF = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
  } opcode_e;

  logic [WIDTH-1:0] regs [NREGS];
  logic [2:0]       cc;
  logic [CNT_W-1:0] pend [NREGS];
  logic [CNT_W-1:0] cc_pend;
  logic [CNT_W-1:0] inflight;

  opcode_e          op;
  logic             use_sr1, use_sr2, use_cc, is_store, dec_ld_reg, dec_ld_cc;
  logic [REG_W-1:0] sr1_id, sr2_id, dr_id;
  logic             wb_byp_reg, wb_byp_cc;
  logic             sr1_ok, sr2_ok, cc_ok, cap_full, hazard;
  logic             out_counted, fire, handoff;
  logic [CNT_W:0]   occ;
  logic [WIDTH-1:0] sr1_val, sr2_val;
  logic [2:0]       cc_val;

  assign op = opcode_e'(in_ir[15:12]);

  always_comb begin
    use_sr1    = 1'b0;
    use_sr2    = 1'b0;
    use_cc     = 1'b0;
    is_store   = 1'b0;
    dec_ld_reg = 1'b0;
    dec_ld_cc  = 1'b0;
    case (op)
      OP_ADD, OP_AND: begin
        use_sr1    = 1'b1;
        use_sr2    = !in_ir[5];
        dec_ld_reg = 1'b1;
        dec_ld_cc  = 1'b1;
      end
      OP_NOT, OP_LDB, OP_LDW, OP_LDI, OP_SHF: begin
        use_sr1    = 1'b1;
        dec_ld_reg = 1'b1;
        dec_ld_cc  = 1'b1;
      end
      OP_STB, OP_STW, OP_STI: begin
        use_sr1  = 1'b1;
        use_sr2  = 1'b1;
        is_store = 1'b1;
      end
      OP_JMP: use_sr1 = 1'b1;
      OP_JSR: begin
        use_sr1    = !in_ir[11];  // JSRR reads its base register, JSR does not
        dec_ld_reg = 1'b1;
      end
      OP_LEA, OP_TRAP: dec_ld_reg = 1'b1;
      OP_BR:           use_cc     = 1'b1;
      default: ;
    endcase
  end

  assign sr1_id = REG_W'(in_ir[8:6]);
  assign sr2_id = is_store ? REG_W'(in_ir[11:9]) : REG_W'(in_ir[2:0]);
  assign dr_id  = (op == OP_JSR || op == OP_TRAP) ? REG_W'(LINK_REG) : REG_W'(in_ir[11:9]);

  assign wb_byp_reg  = wb_valid && wb_we && wb_ld_reg;
  assign wb_byp_cc   = wb_valid && wb_we && wb_ld_cc;
  assign out_counted = out_ld_reg || out_ld_cc;

  // A source is ready when nothing ahead still owes it a value, or the single
  // outstanding writer commits in this very cycle (bypassed below).
  assign sr1_ok = !(out_valid && out_ld_reg && out_drid == sr1_id) &&
                  (pend[sr1_id] == '0 ||
                   (pend[sr1_id] == CNT_W'(1) && wb_byp_reg && wb_drid == sr1_id));
  assign sr2_ok = !(out_valid && out_ld_reg && out_drid == sr2_id) &&
                  (pend[sr2_id] == '0 ||
                   (pend[sr2_id] == CNT_W'(1) && wb_byp_reg && wb_drid == sr2_id));
  assign cc_ok  = !(out_valid && out_ld_cc) &&
                  (cc_pend == '0 || (cc_pend == CNT_W'(1) && wb_byp_cc));

  // The output register counts as in flight even if it leaves this cycle.
  assign occ      = {1'b0, inflight} + {{CNT_W{1'b0}}, out_valid && out_counted};
  assign cap_full = (dec_ld_reg || dec_ld_cc) && (occ >= (CNT_W+1)'(MAX_INFLIGHT));
  assign hazard   = (use_sr1 && !sr1_ok) || (use_sr2 && !sr2_ok) || (use_cc && !cc_ok) || cap_full;

  assign in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  assign sr1_val = (wb_byp_reg && wb_drid == sr1_id) ? wb_data : regs[sr1_id];
  assign sr2_val = (wb_byp_reg && wb_drid == sr2_id) ? wb_data : regs[sr2_id];
  assign cc_val  = wb_byp_cc ? wb_cc : cc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_npc    <= '0;
      out_ir     <= '0;
      out_sr1    <= '0;
      out_sr2    <= '0;
      out_drid   <= '0;
      out_cc     <= '0;
      out_ld_reg <= 1'b0;
      out_ld_cc  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid  <= 1'b1;
      out_npc    <= in_npc;
      out_ir     <= in_ir;
      out_sr1    <= sr1_val;
      out_sr2    <= sr2_val;
      out_drid   <= dr_id;
      out_cc     <= cc_val;
      out_ld_reg <= dec_ld_reg;
      out_ld_cc  <= dec_ld_cc;
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      cc       <= 3'b010;
      cc_pend  <= '0;
      inflight <= '0;
    end else begin
      if (wb_valid) begin
        assert (inflight != '0);
        if (wb_ld_reg) assert (pend[wb_drid] != '0);
        if (wb_ld_cc)  assert (cc_pend != '0);
      end
      // Squashed retirements (wb_we=0) still release their scoreboard slots.
      for (int unsigned r = 0; r < NREGS; r++) begin
        pend[r] <= pend[r]
                 + CNT_W'(handoff && out_ld_reg && out_drid == REG_W'(r))
                 - CNT_W'(wb_valid && wb_ld_reg && wb_drid == REG_W'(r));
      end
      cc_pend  <= cc_pend + CNT_W'(handoff && out_ld_cc) - CNT_W'(wb_valid && wb_ld_cc);
      inflight <= inflight + CNT_W'(handoff && out_counted) - CNT_W'(wb_valid);
      if (wb_byp_reg) regs[wb_drid] <= wb_data;
      if (wb_byp_cc)  cc <= wb_cc;
    end
  end

endmodule

// File: tb/tb_decode_sb.sv
// tb_decode_sb: directed bench for decode_sb. Expected output records are
// queued when an instruction is accepted and compared when it leaves.
module tb_decode_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_npc, in_ir;
  logic        out_valid, out_ready;
  logic [15:0] out_npc, out_ir, out_sr1, out_sr2;
  logic [2:0]  out_drid, out_cc;
  logic        out_ld_reg, out_ld_cc;
  logic        flush;
  logic        wb_valid, wb_we;
  logic [2:0]  wb_drid;
  logic [15:0] wb_data;
  logic        wb_ld_reg, wb_ld_cc;
  logic [2:0]  wb_cc;

  always #5 clk = ~clk;

  decode_sb #(.WIDTH(16), .NREGS(8), .LINK_REG(7), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_npc(in_npc), .in_ir(in_ir),
    .out_valid(out_valid), .out_ready(out_ready), .out_npc(out_npc), .out_ir(out_ir),
    .out_sr1(out_sr1), .out_sr2(out_sr2), .out_drid(out_drid), .out_cc(out_cc),
    .out_ld_reg(out_ld_reg), .out_ld_cc(out_ld_cc), .flush(flush),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_drid(wb_drid), .wb_data(wb_data),
    .wb_ld_reg(wb_ld_reg), .wb_ld_cc(wb_ld_cc), .wb_cc(wb_cc)
  );

  typedef struct packed {
    logic [15:0] npc, ir, sr1, sr2;
    logic [2:0]  drid, cc;
    logic        ldr, ldc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] regs_m [8];
  logic [2:0]  cc_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_m(input logic [2:0] id);
    if (wb_valid && wb_we && wb_ld_reg && wb_drid == id) return wb_data;
    return regs_m[id];
  endfunction

  task automatic push(input logic [15:0] npc, input logic [15:0] ir,
                      input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                      input logic ldr, input logic ldc);
    exp_t e;
    e.npc  = npc;
    e.ir   = ir;
    e.sr1  = rd_m(s1);
    e.sr2  = rd_m(s2);
    e.drid = d;
    e.cc   = (wb_valid && wb_we && wb_ld_cc) ? wb_cc : cc_m;
    e.ldr  = ldr;
    e.ldc  = ldc;
    sb.push_back(e);
  endtask

  task automatic chk_out(input bit pop);
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb[0];
    chk("out_valid", out_valid, 1);
    chk("out_npc", out_npc, e.npc);
    chk("out_ir", out_ir, e.ir);
    chk("out_sr1", out_sr1, e.sr1);
    chk("out_sr2", out_sr2, e.sr2);
    chk("out_drid", out_drid, e.drid);
    chk("out_cc", out_cc, e.cc);
    chk("out_ld_reg", out_ld_reg, e.ldr);
    chk("out_ld_cc", out_ld_cc, e.ldc);
    if (pop) void'(sb.pop_front());
  endtask

  // Advance past the next rising edge, committing the modelled writeback.
  task automatic next();
    @(posedge clk);
    if (wb_valid && wb_we && wb_ld_reg) regs_m[wb_drid] = wb_data;
    if (wb_valid && wb_we && wb_ld_cc)  cc_m = wb_cc;
    #1;
    wb_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic set_wb(input logic we, input logic [2:0] d, input logic [15:0] data,
                        input logic ldr, input logic ldc, input logic [2:0] c);
    wb_valid = 1'b1; wb_we = we; wb_drid = d; wb_data = data;
    wb_ld_reg = ldr; wb_ld_cc = ldc; wb_cc = c;
  endtask

  initial begin
    in_valid = 0; in_npc = '0; in_ir = '0; out_ready = 1; flush = 0;
    wb_valid = 0; wb_we = 0; wb_drid = '0; wb_data = '0; wb_ld_reg = 0; wb_ld_cc = 0; wb_cc = '0;
    for (int i = 0; i < 8; i++) regs_m[i] = '0;
    cc_m  = 3'b010;
    rst_n = 1'b0;

    // reset state
    repeat (2) next();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_npc", out_npc, 0);
    chk("rst_out_ir", out_ir, 0);
    chk("rst_out_sr1", out_sr1, 0);
    chk("rst_out_sr2", out_sr2, 0);
    chk("rst_out_drid", out_drid, 0);
    chk("rst_out_cc", out_cc, 0);
    chk("rst_out_ld", {out_ld_reg, out_ld_cc}, 0);
    next(); rst_n = 1'b1;
    @(negedge clk); chk("idle_in_ready", in_ready, 1);
    next();

    // BR reads the reset CC
    in_valid = 1; in_npc = 16'h3002; in_ir = 16'h0E05;
    @(negedge clk); chk("br_in_ready", in_ready, 1); push(16'h3002, 16'h0E05, 0, 5, 7, 0, 0);
    next(); in_valid = 0;
    @(negedge clk); chk_out(1);
    next();
    @(negedge clk); chk("br_drained", out_valid, 0);
    next();

    // RAW: ADD R1<-R0+R0 then ADD R2<-R1+R1, issued with bypass
    in_valid = 1; in_npc = 16'h3004; in_ir = 16'h1200;
    @(negedge clk); chk("add1_in_ready", in_ready, 1); push(16'h3004, 16'h1200, 0, 0, 1, 1, 1);
    next(); in_npc = 16'h3006; in_ir = 16'h1441;
    @(negedge clk); chk_out(1); chk("raw_outreg_stall", in_ready, 0);
    next();
    @(negedge clk); chk("raw_pend_stall", in_ready, 0);
    next();
    @(negedge clk); chk("raw_pend_stall2", in_ready, 0);
    next(); set_wb(1, 1, 16'h1234, 1, 1, 3'b010);
    @(negedge clk); chk("bypass_in_ready", in_ready, 1); push(16'h3006, 16'h1441, 1, 1, 2, 1, 1);
    next(); in_valid = 0;
    @(negedge clk); chk_out(1);
    next(); set_wb(1, 2, 16'h00AA, 1, 1, 3'b010);
    @(negedge clk); chk("add2_gone", out_valid, 0);
    next();

    // back-pressure: hold ADD R3<-R1+R2 for 3 cycles
    out_ready = 0; in_valid = 1; in_npc = 16'h3008; in_ir = 16'h1642;
    @(negedge clk); chk("add3_in_ready", in_ready, 1); push(16'h3008, 16'h1642, 1, 2, 3, 1, 1);
    next(); in_npc = 16'h300A; in_ir = 16'h1821;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk_out(0); chk("hold_in_ready", in_ready, 0);
      next();
    end
    out_ready = 1; in_valid = 0;
    @(negedge clk); chk_out(1);
    next(); in_ir = 16'h1AE0;
    @(negedge clk); chk("pend3_stall", in_ready, 0);
    next(); set_wb(1, 3, 16'h0F0F, 1, 1, 3'b010);
    @(negedge clk); chk("pend3_bypass_ready", in_ready, 1);
    next();

    // flush and squashed retirement
    in_valid = 1; in_npc = 16'h300C; in_ir = 16'h1821;
    @(negedge clk); chk("r4_in_ready", in_ready, 1); push(16'h300C, 16'h1821, 0, 1, 4, 1, 1);
    next(); in_npc = 16'h300E; in_ir = 16'h1C22;
    @(negedge clk); chk_out(1); chk("r6_in_ready", in_ready, 1); push(16'h300E, 16'h1C22, 0, 2, 6, 1, 1);
    next(); out_ready = 0; flush = 1; in_npc = 16'h3010; in_ir = 16'h1E23;
    @(negedge clk); chk("flush_in_ready", in_ready, 0); chk_out(0);
    next(); void'(sb.pop_front()); in_valid = 0; in_ir = 16'h1120;
    @(negedge clk); chk("flush_out_valid", out_valid, 0); chk("pend4_kept", in_ready, 0);
    next(); in_ir = 16'h11A0;
    @(negedge clk); chk("pend6_clear", in_ready, 1);
    next(); in_ir = 16'h1120; set_wb(0, 4, 16'hDEAD, 1, 1, 3'b100);
    @(negedge clk); chk("squash_no_bypass", in_ready, 0);
    next();
    out_ready = 1; in_valid = 1; in_npc = 16'h3012; in_ir = 16'h1304;
    @(negedge clk); chk("squash_pend_zero", in_ready, 1); push(16'h3012, 16'h1304, 4, 4, 1, 1, 1);
    next(); in_valid = 0;
    @(negedge clk); chk_out(1);
    next(); set_wb(1, 1, 16'h7777, 1, 1, 3'b001);
    @(negedge clk); chk("r1_gone", out_valid, 0);
    next();

    // in-flight limit: five independent ADD Rd<-R0+#0
    in_valid = 1;
    for (int d = 1; d <= 4; d++) begin
      in_npc = 16'h3100 + 16'(d);
      in_ir  = 16'h1020 | 16'(d << 9);
      @(negedge clk);
      if (d > 1) chk_out(1);
      chk("cap_in_ready", in_ready, 1);
      push(in_npc, in_ir, 0, 0, 3'(d), 1, 1);
      next();
    end
    in_npc = 16'h3105; in_ir = 16'h1A20;
    @(negedge clk); chk_out(1); chk("cap_fifth_block", in_ready, 0);
    next();
    @(negedge clk); chk("cap_drained", out_valid, 0); chk("cap_full_block", in_ready, 0);
    next(); set_wb(1, 1, 16'h0101, 1, 1, 3'b001);
    @(negedge clk); chk("cap_no_credit", in_ready, 0);
    next();
    @(negedge clk); chk("cap_after_wb", in_ready, 1); push(16'h3105, 16'h1A20, 0, 0, 5, 1, 1);
    next(); in_valid = 0;
    @(negedge clk); chk_out(1);
    next();
    for (int d = 2; d <= 5; d++) begin
      set_wb(1, 3'(d), 16'h0200 + 16'(d), 1, 1, 3'b001);
      @(negedge clk);
      next();
    end

    // JSR link destination; STW reads ir[11:9] as sr2
    in_valid = 1; in_npc = 16'h3200; in_ir = 16'h4800;
    @(negedge clk); chk("jsr_in_ready", in_ready, 1); push(16'h3200, 16'h4800, 0, 0, 7, 1, 0);
    next(); in_npc = 16'h3202; in_ir = 16'h1620;
    @(negedge clk); chk_out(1); chk("add_r3_in_ready", in_ready, 1); push(16'h3202, 16'h1620, 0, 0, 3, 1, 1);
    next(); in_npc = 16'h3204; in_ir = 16'h7680;
    @(negedge clk); chk_out(1); chk("stw_outreg_stall", in_ready, 0);
    next();
    @(negedge clk); chk("stw_pend_stall", in_ready, 0);
    next(); set_wb(1, 3, 16'h5555, 1, 1, 3'b100);
    @(negedge clk); chk("stw_bypass", in_ready, 1); push(16'h3204, 16'h7680, 2, 3, 3, 0, 0);
    next(); in_valid = 0;
    @(negedge clk); chk_out(1);
    next();

    // BR waits on a pending CC writer and takes the bypassed NZP
    in_valid = 1; in_npc = 16'h3300; in_ir = 16'h1C20;
    @(negedge clk); chk("r6b_in_ready", in_ready, 1); push(16'h3300, 16'h1C20, 0, 0, 6, 1, 1);
    next(); in_npc = 16'h3302; in_ir = 16'h0E00;
    @(negedge clk); chk_out(1); chk("br_cc_outreg_stall", in_ready, 0);
    next();
    @(negedge clk); chk("br_cc_pend_stall", in_ready, 0);
    next(); set_wb(1, 6, 16'h0666, 1, 1, 3'b001);
    @(negedge clk); chk("br_cc_bypass", in_ready, 1); push(16'h3302, 16'h0E00, 0, 0, 7, 0, 0);
    next(); in_valid = 0;
    @(negedge clk); chk_out(1);
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
